// File: rtl/axi_ic_pkg.sv
// Shared types for the interconnect2x2 write-path controller: FSM encoding,
// master/slave counts, the per-master handshake bundle and the slave-decode helper.
package axi_ic_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int NUM_SLAVES  = 2;
    localparam int MIDX_W      = 1;

    typedef logic [MIDX_W-1:0] midx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } wr_state_e;

    // Handshake signals of one master as seen on the master side of the interconnect
    typedef struct packed {
        logic awvalid;
        logic awready;
        logic wvalid;
        logic wready;
        logic wlast;
        logic bvalid;
        logic bready;
    } m_wr_hs_t;

    // The top address bit picks the slave
    function automatic int slave_sel_bit(input int addr_width);
        return addr_width - 1;
    endfunction

    function automatic logic [NUM_MASTERS-1:0] m_onehot(input midx_t idx);
        logic [NUM_MASTERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/axi_wr_slave_fsm.sv
// Per-slave write sequencer: round-robin grant, AW/W/B sequencing with done flags.
// Optional watchdog enabled by defining AXI_WR_TIMEOUT_EN.
module axi_wr_slave_fsm
    import axi_ic_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic     [NUM_MASTERS-1:0]   req,
    input  m_wr_hs_t [NUM_MASTERS-1:0]   hs,
    output logic     [NUM_MASTERS-1:0]   gnt_pulse,
    output logic     [NUM_MASTERS-1:0]   busy,
    output logic     [NUM_MASTERS-1:0]   addr_en,
    output logic     [NUM_MASTERS-1:0]   data_en,
    output logic                         resp_en,
    output logic                         resp_sel,
    output logic                         timeout
);

    if (TIMEOUT_CYCLES < 2) begin : g_cfg_chk
        $error("axi_wr_slave_fsm: TIMEOUT_CYCLES must be at least 2");
    end

    wr_state_e              state_q, state_d;
    midx_t                  gnt_q, gnt_d;
    midx_t                  rr_q, rr_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [NUM_MASTERS-1:0] addr_en_q, addr_en_d;
    logic [NUM_MASTERS-1:0] data_en_q, data_en_d;
    logic                   resp_en_q, resp_en_d;
    logic                   resp_sel_q, resp_sel_d;

    m_wr_hs_t hs_g;
    logic     aw_hs, w_hs, b_hs;

    assign hs_g  = hs[gnt_q];
    assign aw_hs = hs_g.awvalid & hs_g.awready;
    assign w_hs  = hs_g.wvalid & hs_g.wready & hs_g.wlast;
    assign b_hs  = hs_g.bvalid & hs_g.bready;

`ifdef AXI_WR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q;
    logic             to_q, to_d;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        addr_en_d  = addr_en_q;
        data_en_d  = data_en_q;
        resp_en_d  = resp_en_q;
        resp_sel_d = resp_sel_q;
        gnt_pulse  = '0;
`ifdef AXI_WR_TIMEOUT_EN
        to_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    // On a tie the master that did not win last time goes first
                    if (&req) begin
                        gnt_d = ~rr_q;
                        rr_d  = ~rr_q;
                    end else begin
                        gnt_d = midx_t'(req[1]);
                    end
                    gnt_pulse = m_onehot(gnt_d);
                    state_d   = ST_XFER;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    addr_en_d = m_onehot(gnt_d);
                    data_en_d = m_onehot(gnt_d);
                end
            end
            ST_XFER: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d) addr_en_d = '0;
                if (w_done_d)  data_en_d = '0;
                if (aw_done_d && w_done_d) begin
                    state_d    = ST_RESP;
                    resp_en_d  = 1'b1;
                    resp_sel_d = gnt_q;
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_d   = ST_IDLE;
                    resp_en_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                addr_en_d = '0;
                data_en_d = '0;
                resp_en_d = 1'b0;
            end
        endcase
`ifdef AXI_WR_TIMEOUT_EN
        // Watchdog overrides whatever the channel handshakes asked for
        if (state_q != ST_IDLE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = ST_IDLE;
            addr_en_d = '0;
            data_en_d = '0;
            resp_en_d = 1'b0;
            to_d      = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            rr_q       <= midx_t'(1);
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            addr_en_q  <= '0;
            data_en_q  <= '0;
            resp_en_q  <= 1'b0;
            resp_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            addr_en_q  <= addr_en_d;
            data_en_q  <= data_en_d;
            resp_en_q  <= resp_en_d;
            resp_sel_q <= resp_sel_d;
        end
    end

`ifdef AXI_WR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            to_q <= to_d;
            if (state_q == ST_IDLE) cnt_q <= '0;
            else                    cnt_q <= cnt_q + 1'b1;
        end
    end
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign busy     = (state_q != ST_IDLE) ? m_onehot(gnt_q) : '0;
    assign addr_en  = addr_en_q;
    assign data_en  = data_en_q;
    assign resp_en  = resp_en_q;
    assign resp_sel = resp_sel_q;

endmodule

// File: rtl/axi_wr_arbiter2x2.sv
// Write-path controller for interconnect2x2: address decode, busy masks and the
// merge of both slave sequencers onto the master-side route controls.
// Optional per-slave watchdog enabled by defining AXI_WR_TIMEOUT_EN.
module axi_wr_arbiter2x2
    import axi_ic_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] M0_AWADDR,
    input  logic                  M0_AWVALID,
    input  logic                  M0_AWREADY,
    input  logic                  M0_WVALID,
    input  logic                  M0_WREADY,
    input  logic                  M0_WLAST,
    input  logic                  M0_BVALID,
    input  logic                  M0_BREADY,
    input  logic [ADDR_WIDTH-1:0] M1_AWADDR,
    input  logic                  M1_AWVALID,
    input  logic                  M1_AWREADY,
    input  logic                  M1_WVALID,
    input  logic                  M1_WREADY,
    input  logic                  M1_WLAST,
    input  logic                  M1_BVALID,
    input  logic                  M1_BREADY,
    output logic                  M0_write_addr_sel,
    output logic                  M0_write_addr_en,
    output logic                  M0_write_data_sel,
    output logic                  M0_write_data_en,
    output logic                  M1_write_addr_sel,
    output logic                  M1_write_addr_en,
    output logic                  M1_write_data_sel,
    output logic                  M1_write_data_en,
    output logic                  S0_write_resp_sel,
    output logic                  S0_write_resp_en,
    output logic                  S1_write_resp_sel,
    output logic                  S1_write_resp_en,
    output logic [1:0]            wr_timeout
);

    localparam int SEL_BIT = slave_sel_bit(ADDR_WIDTH);

    logic     [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  awaddr;
    m_wr_hs_t [NUM_MASTERS-1:0]                  hs;
    logic     [NUM_SLAVES-1:0][NUM_MASTERS-1:0]  req, slv_gnt, slv_busy, slv_addr_en, slv_data_en;
    logic     [NUM_SLAVES-1:0]                   slv_resp_en, slv_resp_sel, slv_timeout;
    logic     [NUM_MASTERS-1:0]                  busy, addr_en_m, data_en_m, wsel_q;
    logic                                        unused_addr_bits;

    assign awaddr[0] = M0_AWADDR;
    assign awaddr[1] = M1_AWADDR;
    assign hs[0] = {M0_AWVALID, M0_AWREADY, M0_WVALID, M0_WREADY, M0_WLAST, M0_BVALID, M0_BREADY};
    assign hs[1] = {M1_AWVALID, M1_AWREADY, M1_WVALID, M1_WREADY, M1_WLAST, M1_BVALID, M1_BREADY};
    assign unused_addr_bits = ^{awaddr[0][SEL_BIT-1:0], awaddr[1][SEL_BIT-1:0]};

    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slv
        for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_req
            assign req[s][m] = hs[m].awvalid & (awaddr[m][SEL_BIT] == 1'(s)) & ~busy[m];
        end

        axi_wr_slave_fsm #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_slave_fsm (
            .clk       (ACLK),
            .rst       (ARESET),
            .req       (req[s]),
            .hs        (hs),
            .gnt_pulse (slv_gnt[s]),
            .busy      (slv_busy[s]),
            .addr_en   (slv_addr_en[s]),
            .data_en   (slv_data_en[s]),
            .resp_en   (slv_resp_en[s]),
            .resp_sel  (slv_resp_sel[s]),
            .timeout   (slv_timeout[s])
        );
    end

    // A master is served by at most one slave, so OR-merging is collision free
    always_comb begin
        busy      = '0;
        addr_en_m = '0;
        data_en_m = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            busy      = busy | slv_busy[s];
            addr_en_m = addr_en_m | slv_addr_en[s];
            data_en_m = data_en_m | slv_data_en[s];
        end
    end

    // Route select is captured on grant and held until the next grant
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wsel_q <= '0;
        end else begin
            for (int m = 0; m < NUM_MASTERS; m++)
                for (int s = 0; s < NUM_SLAVES; s++)
                    if (slv_gnt[s][m]) wsel_q[m] <= 1'(s);
        end
    end

    assign M0_write_addr_sel = wsel_q[0];
    assign M0_write_data_sel = wsel_q[0];
    assign M1_write_addr_sel = wsel_q[1];
    assign M1_write_data_sel = wsel_q[1];
    assign M0_write_addr_en  = addr_en_m[0];
    assign M0_write_data_en  = data_en_m[0];
    assign M1_write_addr_en  = addr_en_m[1];
    assign M1_write_data_en  = data_en_m[1];
    assign S0_write_resp_sel = slv_resp_sel[0];
    assign S0_write_resp_en  = slv_resp_en[0];
    assign S1_write_resp_sel = slv_resp_sel[1];
    assign S1_write_resp_en  = slv_resp_en[1];
    assign wr_timeout        = slv_timeout;

endmodule
